dl_demux3_buf: RTL and testbench

DL_DEMUX3_BUF -- requirements
Module: dl_demux3_buf

---
 rtl/dl_demux3_buf_if.sv | 24 ++
 rtl/dl_demux3_buf.sv | 93 +++++++++
 tb/tb_dl_demux3_buf.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/dl_demux3_buf_if.sv
// Bundle of the upstream beat channel, the three downstream channels and the
// sticky select-error flag for dl_demux3_buf.
interface dl_demux3_buf_if #(parameter int NUM_BITS = 32);
   logic                in_val;
   logic                in_rdy;
   logic [NUM_BITS-1:0] in_data;
   logic [1:0]          in_sel;
   logic                out0_val, out1_val, out2_val;
   logic                out0_rdy, out1_rdy, out2_rdy;
   logic [NUM_BITS-1:0] out0_data, out1_data, out2_data;
   logic                sel_err;

   modport master (
      output in_val, in_data, in_sel, out0_rdy, out1_rdy, out2_rdy,
      input  in_rdy, out0_val, out1_val, out2_val,
      input  out0_data, out1_data, out2_data, sel_err
   );

   modport slave (
      input  in_val, in_data, in_sel, out0_rdy, out1_rdy, out2_rdy,
      output in_rdy, out0_val, out1_val, out2_val,
      output out0_data, out1_data, out2_data, sel_err
   );
endinterface

// File: rtl/dl_demux3_buf.sv
// One-to-three demux; every output has its own 2-entry FIFO so a stalled
// output never blocks beats for the others. Beats with select 3 are dropped.
module dl_demux3_buf_fifo #(parameter int W = 32) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic         full,
   output logic         val,
   output logic [W-1:0] rdata
);
   logic [1:0][W-1:0] mem;
   logic              wr_ptr, rd_ptr;
   logic [1:0]        cnt;

   // storage needs no reset: rdata is only looked at while cnt != 0
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= wdata;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign full  = (cnt == 2'd2);
   assign val   = (cnt != 2'd0);
   assign rdata = mem[rd_ptr];
endmodule

module dl_demux3_buf #(parameter int NUM_BITS = 32) (
   input logic            clk,
   input logic            rst_n,
   dl_demux3_buf_if.slave bus
);
   localparam int NUM_LANES = 3;

   logic [NUM_LANES-1:0]               push, pop, full, val, rdy;
   logic [NUM_LANES-1:0][NUM_BITS-1:0] rdata;
   logic                               in_rdy;
   logic                               sel_err_q;

   assign rdy = {bus.out2_rdy, bus.out1_rdy, bus.out0_rdy};
   assign pop = val & rdy;

   // in_rdy looks only at registered fullness; select 3 is always taken
   always_comb begin
      in_rdy = 1'b1;
      push   = '0;
      for (int i = 0; i < NUM_LANES; i++)
         if (bus.in_sel == 2'(i)) in_rdy = !full[i];
      for (int i = 0; i < NUM_LANES; i++)
         push[i] = bus.in_val && in_rdy && (bus.in_sel == 2'(i));
   end

   always_ff @(posedge clk) begin
      if (!rst_n)                                 sel_err_q <= 1'b0;
      else if (bus.in_val && bus.in_sel == 2'd3) sel_err_q <= 1'b1;
   end

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      dl_demux3_buf_fifo #(.W(NUM_BITS)) u_fifo (
         .clk   (clk),
         .rst_n (rst_n),
         .push  (push[g]),
         .wdata (bus.in_data),
         .pop   (pop[g]),
         .full  (full[g]),
         .val   (val[g]),
         .rdata (rdata[g])
      );
   end

   assign bus.in_rdy    = in_rdy;
   assign bus.sel_err   = sel_err_q;
   assign bus.out0_val  = val[0];
   assign bus.out1_val  = val[1];
   assign bus.out2_val  = val[2];
   assign bus.out0_data = rdata[0];
   assign bus.out1_data = rdata[1];
   assign bus.out2_data = rdata[2];
endmodule

// File: tb/tb_dl_demux3_buf.sv
// Table of hand-derived cycles (in_rdy / out valids / sel_err) with a data
// scoreboard per output, followed by a random phase checked against queues.
module tb_dl_demux3_buf;
   logic clk, rst_n;
   dl_demux3_buf_if #(.NUM_BITS(32)) bus ();

   dl_demux3_buf #(.NUM_BITS(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n, val;
      logic [1:0]  sel;
      logic [31:0] data;
      logic [2:0]  rdy;     // {out2,out1,out0}
      logic        e_rdy;
      logic [2:0]  e_val;   // {out2,out1,out0}
      logic        e_err;
   } vec_t;

   vec_t        tbl[$];
   logic [31:0] q0[$], q1[$], q2[$];
   int          vectors = 0;
   int          miscompares = 0;

   function automatic void add(logic r, logic v, logic [1:0] s, logic [31:0] d,
                               logic [2:0] rd, logic er, logic [2:0] ev, logic ee);
      vec_t t;
      t.rst_n = r; t.val = v; t.sel = s; t.data = d; t.rdy = rd;
      t.e_rdy = er; t.e_val = ev; t.e_err = ee;
      tbl.push_back(t);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int qsize(int n);
      case (n)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic one_cycle(input logic r, input logic v, input logic [1:0] s,
                            input logic [31:0] d, input logic [2:0] rd,
                            input logic er, input logic [2:0] ev, input logic ee,
                            input bit chk_rdy);
      logic [2:0]  av;
      logic [31:0] ad [3];
      @(negedge clk);
      rst_n = r; bus.in_val = v; bus.in_sel = s; bus.in_data = d;
      bus.out0_rdy = rd[0]; bus.out1_rdy = rd[1]; bus.out2_rdy = rd[2];
      #1;
      av = {bus.out2_val, bus.out1_val, bus.out0_val};
      ad[0] = bus.out0_data; ad[1] = bus.out1_data; ad[2] = bus.out2_data;
      if (chk_rdy) chk("in_rdy", {31'd0, bus.in_rdy}, {31'd0, er});
      chk("out_val", {29'd0, av}, {29'd0, ev});
      chk("sel_err", {31'd0, bus.sel_err}, {31'd0, ee});
      for (int n = 0; n < 3; n++) begin
         if (ev[n]) begin
            if (qsize(n) == 0) begin
               vectors++; miscompares++;
               $display("FAIL sb_empty out%0d: got %h, expected no beat", n, ad[n]);
            end else begin
               case (n)
                  0:       chk("out0_data", ad[0], q0[0]);
                  1:       chk("out1_data", ad[1], q1[0]);
                  default: chk("out2_data", ad[2], q2[0]);
               endcase
            end
         end
      end
      if (!r) begin
         q0.delete(); q1.delete(); q2.delete();
      end else begin
         if (ev[0] && rd[0] === 1'b1 && q0.size() != 0) void'(q0.pop_front());
         if (ev[1] && rd[1] === 1'b1 && q1.size() != 0) void'(q1.pop_front());
         if (ev[2] && rd[2] === 1'b1 && q2.size() != 0) void'(q2.pop_front());
         if (v && er) begin
            case (s)
               2'd0:    q0.push_back(d);
               2'd1:    q1.push_back(d);
               2'd2:    q2.push_back(d);
               default: ;
            endcase
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; bus.in_val = 1'b0; bus.in_sel = 2'd0; bus.in_data = '0;
      bus.out0_rdy = 1'b0; bus.out1_rdy = 1'b0; bus.out2_rdy = 1'b0;
      repeat (2) @(posedge clk);

      // post-reset state, in_rdy for several selects
      add(1, 0, 0, 0, 3'b000, 1, 3'b000, 0);
      add(1, 0, 3, 0, 3'b000, 1, 3'b000, 0);
      add(1, 0, 2, 0, 3'b000, 1, 3'b000, 0);
      // basic routing to out1
      add(1, 1, 1, 32'hA5A5_0001, 3'b010, 1, 3'b000, 0);
      add(1, 0, 1, 0,             3'b010, 1, 3'b010, 0);
      add(1, 0, 1, 0,             3'b000, 1, 3'b000, 0);
      // fill out0 and backpressure
      add(1, 1, 0, 32'h11, 3'b000, 1, 3'b000, 0);
      add(1, 1, 0, 32'h22, 3'b000, 1, 3'b001, 0);
      add(1, 1, 0, 32'h33, 3'b000, 0, 3'b001, 0);
      add(1, 1, 0, 32'h33, 3'b001, 0, 3'b001, 0);
      add(1, 1, 0, 32'h33, 3'b001, 1, 3'b001, 0);
      add(1, 0, 0, 0,      3'b001, 1, 3'b001, 0);
      add(1, 0, 0, 0,      3'b000, 1, 3'b000, 0);
      // out2 full and stalled does not block out0
      add(1, 1, 2, 32'h55, 3'b000, 1, 3'b000, 0);
      add(1, 1, 2, 32'h66, 3'b000, 1, 3'b100, 0);
      add(1, 1, 2, 32'h77, 3'b000, 0, 3'b100, 0);
      add(1, 1, 0, 32'h44, 3'b000, 1, 3'b100, 0);
      add(1, 0, 0, 0,      3'b000, 1, 3'b101, 0);
      // invalid select, sticky error
      add(1, 1, 3, 32'hDEAD, 3'b000, 1, 3'b101, 0);
      add(1, 0, 0, 0,        3'b000, 1, 3'b101, 1);
      add(1, 0, 0, 0,        3'b101, 1, 3'b101, 1);
      add(1, 0, 0, 0,        3'b101, 1, 3'b100, 1);
      add(1, 0, 0, 0,        3'b000, 1, 3'b000, 1);
      // streaming 0..9 through out1, pointer wrap, push+pop at count 1
      for (int i = 0; i < 10; i++)
         add(1, 1, 1, 32'(i), 3'b010, 1, (i == 0) ? 3'b000 : 3'b010, 1);
      add(1, 0, 1, 0, 3'b010, 1, 3'b010, 1);
      add(1, 0, 1, 0, 3'b000, 1, 3'b000, 1);
      // all FIFOs to count 2, then one reset cycle carrying handshakes
      add(1, 1, 0, 32'h100, 3'b000, 1, 3'b000, 1);
      add(1, 1, 0, 32'h101, 3'b000, 1, 3'b001, 1);
      add(1, 1, 1, 32'h110, 3'b000, 1, 3'b001, 1);
      add(1, 1, 1, 32'h111, 3'b000, 1, 3'b011, 1);
      add(1, 1, 2, 32'h120, 3'b000, 1, 3'b011, 1);
      add(1, 1, 2, 32'h121, 3'b000, 1, 3'b111, 1);
      add(0, 1, 3, 32'h200, 3'b111, 1, 3'b111, 1);
      add(1, 1, 2, 32'hBEEF, 3'b000, 1, 3'b000, 0);
      add(1, 0, 0, 0,        3'b100, 1, 3'b100, 0);
      add(1, 0, 0, 0,        3'b000, 1, 3'b000, 0);

      foreach (tbl[i])
         one_cycle(tbl[i].rst_n, tbl[i].val, tbl[i].sel, tbl[i].data, tbl[i].rdy,
                   tbl[i].e_rdy, tbl[i].e_val, tbl[i].e_err, 1'b1);

      // random traffic; idle fields driven to X where they must be ignored
      begin
         logic        err_m = 1'b0;
         for (int c = 0; c < 400; c++) begin
            logic        v, er;
            logic [1:0]  s;
            logic [31:0] d;
            logic [2:0]  rd, ev;
            v = 1'($urandom_range(0, 1));
            s = 2'($urandom_range(0, 3));
            d = $urandom;
            for (int n = 0; n < 3; n++) begin
               ev[n] = (qsize(n) != 0);
               rd[n] = ev[n] ? 1'($urandom_range(0, 1)) : 1'bx;
            end
            er = (s == 2'd3) ? 1'b1 : (qsize(int'(s)) != 2);
            if (!v) begin
               s = 2'bxx; d = 'x;
            end
            one_cycle(1'b1, v, s, d, rd, er, ev, err_m, v);
            if (v && s == 2'd3) err_m = 1'b1;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
